pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15: maximum FETCH cycles without imem_ack before fetch fault.
REQ-003 clock  input  1  single system clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clock only.
REQ-005 branch_taken  input  1  next PC comes from branch_target; sampled only on issue handshake.
REQ-006 branch_target  input  8  branch destination address.
REQ-007 halt  input  1  stop fetching after the current issue handshake.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  8  instruction memory address, equal to PC.
REQ-010 imem_ack  input  1  memory read data valid this cycle.
REQ-011 imem_rdata  input  8  instruction byte from memory.
REQ-012 instr_valid  output  1  instr_out/instr_pc hold a valid fetched instruction.
REQ-013 instr_out  output  8  fetched instruction.
REQ-014 instr_pc  output  8  address instr_out was fetched from.
REQ-015 instr_ready  input  1  downstream stage accepts instruction this cycle.
REQ-016 pc_out  output  1x8  current PC register.
REQ-017 halted  output  1  unit is in HALTED state.
REQ-018 fetch_error  output  1  sticky: fetch timed out.

Function
REQ-019 The unit SHALL implement states IDLE, FETCH, ISSUE, HALTED.
REQ-020 IDLE SHALL go to FETCH on the next clock, unless halt=1, which SHALL go to HALTED.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold PC stable until imem_ack.
REQ-022 FETCH with imem_ack=1 SHALL register imem_rdata into instr_out, PC into instr_pc, and go to ISSUE; instr_valid SHALL rise the next cycle (1-cycle ack-to-valid latency).
REQ-023 In ISSUE, instr_valid SHALL be 1, imem_req SHALL be 0, and instr_out/instr_pc SHALL stay stable until instr_valid and instr_ready are both 1.
REQ-024 On the handshake cycle, PC SHALL load branch_target if branch_taken=1, else PC+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-025 After the handshake, the state SHALL go to HALTED if halt=1, else to FETCH; imem_req SHALL reassert on the cycle after the handshake.
REQ-026 Simultaneous halt and branch_taken on the handshake SHALL still update PC to branch_target, then go to HALTED.
REQ-027 branch_taken and halt SHALL be ignored in FETCH, and outside the handshake cycle in ISSUE.
REQ-028 A wait counter SHALL count consecutive FETCH cycles with imem_ack=0 and clear on entering FETCH.
REQ-029 When the count reaches MAX_WAIT, the unit SHALL set fetch_error, drop imem_req and go to HALTED without changing PC.
REQ-030 HALTED SHALL be left only by reset; in HALTED, imem_req=0, instr_valid=0, halted=1.
REQ-031 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-032 While reset=0 at posedge, the unit SHALL load PC=RESET_PC and state IDLE, and clear the wait counter and fetch_error.
REQ-033 Reset values SHALL be: pc_out=imem_addr=RESET_PC, instr_out=instr_pc=8'h00, and imem_req, instr_valid, halted, fetch_error = 0.
REQ-034 Reset asserted mid-FETCH or mid-ISSUE SHALL abort the transaction; any pending instruction SHALL be discarded.

Structure
REQ-035 A shared package SHALL hold the state enumeration, the 8-bit address/data width constant, and the RESET_PC default.
REQ-036 The wait counter with its MAX_WAIT compare SHALL be a sub-module named fetch_timer; the PC register and FSM SHALL be in pc_fetch_unit.

Verification
REQ-037 Reset release, imem_ack on 2nd FETCH cycle with rdata=8'hA5, ready=1 -> instr_valid with instr_out=8'hA5 and instr_pc=8'h00; next imem_addr=8'h01.
REQ-038 PC=8'hFF, handshake with no branch -> pc_out=8'h00 next cycle.
REQ-039 instr_ready held 0 for 4 cycles -> instr_out stable, imem_req=0; ready=1 with branch_taken=1 and target=8'h3C -> imem_addr=8'h3C.
REQ-040 Handshake with halt=1 and branch_taken=1, target=8'h10 -> halted=1, pc_out=8'h10, imem_req stays 0.
REQ-041 imem_ack withheld for 15 cycles -> fetch_error=1, halted=1, pc unchanged; reset=0 then 1 -> all outputs return to reset values.
REQ-042 reset=0 asserted during ISSUE -> instr_valid=0 the next cycle and pc_out=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared state encoding, datapath width and reset PC default
package pc_fetch_unit_pkg;
    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED} state_e;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive unacknowledged fetch cycles and flags the MAX_WAIT-th
module fetch_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting_i,
    output logic expired_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // any cycle that is not a missed fetch restarts the count
    always_comb cnt_d = waiting_i ? cnt_q + 1'b1 : '0;
    assign expired_o = waiting_i && (cnt_q == CW'(MAX_WAIT - 1));
    always_ff @(posedge clock) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch/issue FSM with fetch timeout
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              fetch_error
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
    logic err_q, err_d, expired;

    fetch_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .waiting_i (state_q == S_FETCH && !imem_ack),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:  state_d = halt ? S_HALTED : S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = S_ISSUE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    pc_d    = branch_taken ? branch_target : pc_q + 1'b1;
                    state_d = halt ? S_HALTED : S_FETCH;
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end

    assign imem_req    = state_q == S_FETCH;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr_valid = state_q == S_ISSUE;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign halted      = state_q == S_HALTED;
    assign fetch_error = err_q;
endmodule
